// File: rtl/pipeline_hazard_sequencer_if.sv
// Control bundle between decode/forwarding logic and the hazard sequencer.
// The master side (decode, MDU, trap unit, bus) drives the event inputs; the
// slave side (the sequencer) returns per-register enable/clear, PC enable and status.
interface pipeline_hazard_sequencer_if #(
    parameter int NUM_PIPE_REGS = 4,
    parameter int REG_ADDR_W    = 5
);
    logic [REG_ADDR_W-1:0]    rs1_id;
    logic [REG_ADDR_W-1:0]    rs2_id;
    logic                     use_rs1_id;
    logic                     use_rs2_id;
    logic                     mem_read_exe;
    logic [REG_ADDR_W-1:0]    rd_exe;
    logic                     mdu_op_id;
    logic [REG_ADDR_W-1:0]    rd_id;
    logic                     mdu_wb_valid;
    logic [REG_ADDR_W-1:0]    mdu_wb_rd;
    logic                     pc_sel_mem;
    logic                     trap_taken;
    logic                     mret_exec;
    logic                     stall_pipl;

    logic [NUM_PIPE_REGS-1:0] stage_en;
    logic [NUM_PIPE_REGS-1:0] stage_clr;
    logic                     pc_reg_en;
    logic                     mdu_busy;
    logic [2:0]               hazard_cause;
    logic                     sb_error;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, mem_read_exe, rd_exe,
               mdu_op_id, rd_id, mdu_wb_valid, mdu_wb_rd, pc_sel_mem,
               trap_taken, mret_exec, stall_pipl,
        input  stage_en, stage_clr, pc_reg_en, mdu_busy, hazard_cause, sb_error
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, mem_read_exe, rd_exe,
               mdu_op_id, rd_id, mdu_wb_valid, mdu_wb_rd, pc_sel_mem,
               trap_taken, mret_exec, stall_pipl,
        output stage_en, stage_clr, pc_reg_en, mdu_busy, hazard_cause, sb_error
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer: turns load-use, MDU scoreboard, branch, trap/MRET
// and external-stall events into per-register enable/clear and PC enable.
// All control outputs are combinational from current state and inputs; the
// flush FSM and the MDU scoreboard advance on the rising clock edge.
module pipeline_hazard_sequencer #(
    parameter int NUM_PIPE_REGS = 4,
    parameter int BRANCH_STAGE  = 3,
    parameter int FLUSH_CYCLES  = 2,
    parameter int MAX_MDU_OUT   = 2,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_hazard_sequencer_if.slave  bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int CTR_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int CNT_W    = $clog2(MAX_MDU_OUT + 1);

    localparam logic [CTR_W-1:0] CTR_RELOAD = CTR_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_MDU_OUT);

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_LOAD   = 3'd1;
    localparam logic [2:0] CAUSE_MDU    = 3'd2;
    localparam logic [2:0] CAUSE_BRANCH = 3'd3;
    localparam logic [2:0] CAUSE_FLUSH  = 3'd4;
    localparam logic [2:0] CAUSE_EXT    = 3'd5;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CTR_W-1:0]       ctr_q, ctr_d;
    logic [NUM_REGS-1:0]    sb_q, sb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [NUM_PIPE_REGS-1:0] flush_mask;
    logic [NUM_PIPE_REGS-1:0] branch_mask;
    logic [NUM_PIPE_REGS-1:0] en_c;
    logic [NUM_PIPE_REGS-1:0] clr_c;
    logic                     pc_en_c;
    logic [2:0]               cause_c;

    logic wb_ok;
    logic wb_bad;
    logic rs1_busy;
    logic rs2_busy;
    logic mdu_hz;
    logic load_hz;
    logic issue;
    logic redirect;

    // Trap/MRET clears every register except MEM/WB; a taken branch clears up to BRANCH_STAGE.
    for (genvar gi = 0; gi < NUM_PIPE_REGS; gi++) begin : g_mask
        assign flush_mask[gi]  = (gi < NUM_PIPE_REGS - 1);
        assign branch_mask[gi] = (gi < BRANCH_STAGE);
    end

    assign redirect = bus.trap_taken | bus.mret_exec;

    // A write-back is legal only with an op outstanding and, for a real register, its busy bit set.
    assign wb_ok  = bus.mdu_wb_valid && (cnt_q != '0) &&
                    ((bus.mdu_wb_rd == '0) || sb_q[bus.mdu_wb_rd]);
    assign wb_bad = bus.mdu_wb_valid && !wb_ok;

    // A same-cycle write-back releases its register before the source check.
    assign rs1_busy = sb_q[bus.rs1_id] && !(wb_ok && (bus.mdu_wb_rd == bus.rs1_id));
    assign rs2_busy = sb_q[bus.rs2_id] && !(wb_ok && (bus.mdu_wb_rd == bus.rs2_id));

    assign mdu_hz  = (bus.use_rs1_id && rs1_busy) || (bus.use_rs2_id && rs2_busy) ||
                     (bus.mdu_op_id && (cnt_q == CNT_MAX));
    assign load_hz = bus.mem_read_exe && (bus.rd_exe != '0) &&
                     ((bus.use_rs1_id && (bus.rs1_id == bus.rd_exe)) ||
                      (bus.use_rs2_id && (bus.rs2_id == bus.rd_exe)));

    // Flush FSM next state and prioritised pipeline control outputs.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        en_c    = '1;
        clr_c   = '0;
        pc_en_c = 1'b1;
        cause_c = CAUSE_NONE;
        if (reset) begin
            clr_c   = '1;
            pc_en_c = 1'b0;
        end else if (redirect) begin
            clr_c   = flush_mask;
            cause_c = CAUSE_FLUSH;
            state_d = ST_FLUSH;
            ctr_d   = CTR_RELOAD;
        end else if (bus.stall_pipl) begin
            en_c    = '0;
            pc_en_c = 1'b0;
            cause_c = CAUSE_EXT;
        end else if (state_q == ST_FLUSH) begin
            clr_c   = flush_mask;
            cause_c = CAUSE_FLUSH;
            if (ctr_q == '0) begin
                state_d = ST_RUN;
            end else begin
                ctr_d = ctr_q - CTR_W'(1);
            end
        end else if (bus.pc_sel_mem) begin
            clr_c   = branch_mask;
            cause_c = CAUSE_BRANCH;
        end else if (mdu_hz || load_hz) begin
            en_c[0]  = 1'b0;
            clr_c[1] = 1'b1;
            pc_en_c  = 1'b0;
            cause_c  = mdu_hz ? CAUSE_MDU : CAUSE_LOAD;
        end
    end

    // An MDU op leaves ID only when it actually advances into ID/EXE as a live instruction.
    assign issue = !reset && bus.mdu_op_id && en_c[1] && !clr_c[1] &&
                   (state_q == ST_RUN) && !bus.stall_pipl;

    // Scoreboard, outstanding count and sticky error next state.
    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        err_d = err_q | wb_bad;
        if (wb_ok && (bus.mdu_wb_rd != '0)) begin
            sb_d[bus.mdu_wb_rd] = 1'b0;
        end
        if (issue && (bus.rd_id != '0)) begin
            sb_d[bus.rd_id] = 1'b1;
        end
        if (issue && !wb_ok && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue && wb_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            ctr_q   <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.stage_en     = en_c;
    assign bus.stage_clr    = clr_c;
    assign bus.pc_reg_en    = pc_en_c;
    assign bus.hazard_cause = cause_c;
    assign bus.mdu_busy     = !reset && (cnt_q != '0);
    assign bus.sb_error     = err_q;
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: a driver applies one input set per cycle
// and queues the response predicted by a rule-level model; a monitor pops and
// compares the DUT response between clock edges.
module tb_pipeline_hazard_sequencer;
    localparam int N   = 4;
    localparam int BS  = 3;
    localparam int FC  = 2;
    localparam int MAX = 2;
    localparam int W   = 5;

    typedef struct packed {
        logic         rst;
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic         use1;
        logic         use2;
        logic         mem_read;
        logic [W-1:0] rd_exe;
        logic         mdu_op;
        logic [W-1:0] rd_id;
        logic         wb_v;
        logic [W-1:0] wb_rd;
        logic         br;
        logic         trap;
        logic         mret;
        logic         stall;
    } stim_t;

    typedef struct packed {
        logic [N-1:0] en;
        logic [N-1:0] clr;
        logic         pc;
        logic [2:0]   cause;
        logic         busy;
        logic         err;
    } resp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_txn;
    resp_t exp_q[$];

    // Reference model state: remaining flush cycles, busy registers, ops in flight.
    int  m_flush_left;
    bit  m_busy [0:2**W-1];
    int  m_out;
    bit  m_err;

    pipeline_hazard_sequencer_if #(.NUM_PIPE_REGS(N), .REG_ADDR_W(W)) bus ();

    pipeline_hazard_sequencer #(
        .NUM_PIPE_REGS(N), .BRANCH_STAGE(BS), .FLUSH_CYCLES(FC),
        .MAX_MDU_OUT(MAX), .REG_ADDR_W(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit wb_legal(stim_t s);
        return s.wb_v && (m_out > 0) && ((s.wb_rd == 0) || m_busy[s.wb_rd]);
    endfunction

    function automatic resp_t model_resp(stim_t s);
        resp_t r;
        logic [N-1:0] fmask;
        logic [N-1:0] bmask;
        bit ok, b1, b2, mhz, lhz;
        for (int i = 0; i < N; i++) begin
            fmask[i] = (i < N - 1);
            bmask[i] = (i < BS);
        end
        r.en = '1; r.clr = '0; r.pc = 1'b1; r.cause = 3'd0;
        r.busy = (m_out != 0); r.err = m_err;
        if (s.rst) begin
            r.clr = '1; r.pc = 1'b0; r.busy = 1'b0;
        end else if (s.trap || s.mret) begin
            r.clr = fmask; r.cause = 3'd4;
        end else if (s.stall) begin
            r.en = '0; r.pc = 1'b0; r.cause = 3'd5;
        end else if (m_flush_left > 0) begin
            r.clr = fmask; r.cause = 3'd4;
        end else if (s.br) begin
            r.clr = bmask; r.cause = 3'd3;
        end else begin
            ok  = wb_legal(s);
            b1  = m_busy[s.rs1] && !(ok && s.wb_rd == s.rs1);
            b2  = m_busy[s.rs2] && !(ok && s.wb_rd == s.rs2);
            mhz = (s.use1 && b1) || (s.use2 && b2) || (s.mdu_op && m_out == MAX);
            lhz = s.mem_read && (s.rd_exe != 0) &&
                  ((s.use1 && s.rs1 == s.rd_exe) || (s.use2 && s.rs2 == s.rd_exe));
            if (mhz || lhz) begin
                r.en[0] = 1'b0; r.pc = 1'b0; r.clr[1] = 1'b1;
                r.cause = mhz ? 3'd2 : 3'd1;
            end
        end
        return r;
    endfunction

    task automatic model_step(input stim_t s, input resp_t r);
        bit ok, issue;
        if (s.rst) begin
            m_flush_left = 0; m_out = 0; m_err = 0;
            for (int i = 0; i < 2**W; i++) m_busy[i] = 0;
        end else begin
            ok    = wb_legal(s);
            issue = s.mdu_op && !s.stall && (m_flush_left == 0) && r.en[1] && !r.clr[1];
            if (s.wb_v && !ok) m_err = 1;
            if (ok) begin
                m_out--;
                if (s.wb_rd != 0) m_busy[s.wb_rd] = 0;
            end
            if (issue) begin
                m_out = (m_out + 1 > MAX) ? MAX : m_out + 1;
                if (s.rd_id != 0) m_busy[s.rd_id] = 1;
            end
            if (s.trap || s.mret) m_flush_left = FC;
            else if (!s.stall && m_flush_left > 0) m_flush_left--;
        end
    endtask

    task automatic apply(input stim_t s);
        resp_t r;
        @(negedge clk);
        reset            = s.rst;
        bus.rs1_id       = s.rs1;
        bus.rs2_id       = s.rs2;
        bus.use_rs1_id   = s.use1;
        bus.use_rs2_id   = s.use2;
        bus.mem_read_exe = s.mem_read;
        bus.rd_exe       = s.rd_exe;
        bus.mdu_op_id    = s.mdu_op;
        bus.rd_id        = s.rd_id;
        bus.mdu_wb_valid = s.wb_v;
        bus.mdu_wb_rd    = s.wb_rd;
        bus.pc_sel_mem   = s.br;
        bus.trap_taken   = s.trap;
        bus.mret_exec    = s.mret;
        bus.stall_pipl   = s.stall;
        r = model_resp(s);
        exp_q.push_back(r);
        model_step(s, r);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL txn %0d %s: got %0d expected %0d", n_txn, name, act, exp);
        end
    endtask

    // Monitor: compare every presented response against the queued prediction.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %0d: en=%b clr=%b pc=%b cause=%0d busy=%b err=%b",
                         n_txn, bus.stage_en, bus.stage_clr, bus.pc_reg_en,
                         bus.hazard_cause, bus.mdu_busy, bus.sb_error);
                check("stage_en",     int'(bus.stage_en),     int'(e.en));
                check("stage_clr",    int'(bus.stage_clr),    int'(e.clr));
                check("pc_reg_en",    int'(bus.pc_reg_en),    int'(e.pc));
                check("hazard_cause", int'(bus.hazard_cause), int'(e.cause));
                check("mdu_busy",     int'(bus.mdu_busy),     int'(e.busy));
                check("sb_error",     int'(bus.sb_error),     int'(e.err));
                n_txn++;
            end
        end
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        stim_t s;
        int    q_busy[$];
        n_checks = 0; n_fail = 0; n_txn = 0;
        m_flush_left = 0; m_out = 0; m_err = 0;
        for (int i = 0; i < 2**W; i++) m_busy[i] = 0;

        s = idle(); s.rst = 1'b1;
        repeat (2) apply(s);
        apply(idle());

        // Load-use on rs1.
        s = idle(); s.mem_read = 1; s.rd_exe = 5; s.rs1 = 5; s.use1 = 1;
        apply(s);
        apply(idle());

        // MDU dependency resolved by write-back.
        s = idle(); s.mdu_op = 1; s.rd_id = 7;
        apply(s);
        s = idle(); s.rs2 = 7; s.use2 = 1;
        repeat (3) apply(s);
        s.wb_v = 1; s.wb_rd = 7;
        apply(s);
        apply(idle());

        // Outstanding limit.
        s = idle(); s.mdu_op = 1; s.rd_id = 1; apply(s);
        s.rd_id = 2; apply(s);
        s.rd_id = 3; apply(s);
        s.wb_v = 1; s.wb_rd = 1; apply(s);
        s.wb_v = 0; apply(s);
        apply(s);
        s = idle(); s.wb_v = 1; s.wb_rd = 2; apply(s);
        s.wb_rd = 3; apply(s);

        // Trap flush, then MRET with a stall in the middle.
        s = idle(); s.trap = 1; apply(s);
        repeat (3) apply(idle());
        s = idle(); s.mret = 1; apply(s);
        apply(idle());
        s = idle(); s.stall = 1; apply(s);
        repeat (3) apply(idle());

        // Branch together with a load hazard and an MDU op in ID.
        s = idle(); s.br = 1; s.mem_read = 1; s.rd_exe = 9; s.rs2 = 9; s.use2 = 1;
        s.mdu_op = 1; s.rd_id = 10;
        apply(s);
        apply(idle());

        // Reset in the middle of a flush with two ops in flight, then a stray write-back.
        s = idle(); s.mdu_op = 1; s.rd_id = 4; apply(s);
        s.rd_id = 6; apply(s);
        s = idle(); s.trap = 1; apply(s);
        apply(idle());
        s = idle(); s.rst = 1; apply(s);
        apply(idle());
        s = idle(); s.wb_v = 1; s.wb_rd = 4; apply(s);
        repeat (3) apply(idle());
        s = idle(); s.rst = 1; apply(s);
        apply(idle());

        // Randomized traffic on a small register window to provoke collisions.
        for (int t = 0; t < 400; t++) begin
            s = idle();
            s.rs1      = W'($urandom_range(0, 7));
            s.rs2      = W'($urandom_range(0, 7));
            s.use1     = 1'($urandom % 2);
            s.use2     = 1'($urandom % 2);
            s.mem_read = (($urandom % 4) == 0);
            s.rd_exe   = W'($urandom_range(0, 7));
            s.mdu_op   = (($urandom % 3) == 0);
            s.rd_id    = W'($urandom_range(0, 7));
            if (($urandom % 4) == 0) begin
                s.wb_v = 1;
                q_busy.delete();
                for (int i = 0; i < 2**W; i++) if (m_busy[i]) q_busy.push_back(i);
                if (m_out > 0 && ($urandom % 10) != 0)
                    s.wb_rd = (q_busy.size() > 0) ?
                              W'(q_busy[$urandom_range(0, q_busy.size() - 1)]) : '0;
                else
                    s.wb_rd = W'($urandom_range(0, 7));
            end
            s.br    = (($urandom % 12) == 0);
            s.trap  = (($urandom % 30) == 0);
            s.mret  = (($urandom % 40) == 0);
            s.stall = (($urandom % 10) == 0);
            s.rst   = (($urandom % 150) == 0);
            apply(s);
        end

        apply(idle());
        @(negedge clk);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
